write_back_stage: RTL
=====================

# write_back_stage

Registered, parametrised successor to the single-cycle write-back mux. Selects among ALU result, memory load data and link address, performs sub-word load extraction, and drives the register-file write port from a MEM/WB pipeline register with stall/flush control and a retired-instruction counter. Sits between the memory-access stage and the register file, at the end of the MIPS-style pipeline.

## Interface
Parameters:
- data_len, 32, datapath width (≥16, multiple of 8)
- addr_len, 5, register-address width
- cnt_len, 32, retired-counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents a valid instruction
- in_ready  out  1  stage accepts; equals !stall
- stall  in  1  hold request from hazard unit
- flush  in  1  discard incoming instruction
- reg_write  in  1  instruction writes a register
- wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
- load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others as LW
- byte_off  in  2  low address bits of load
- dest_reg  in  addr_len  destination register
- dataFromAlu  in  data_len  ALU result
- dataFromMemory  in  data_len  raw aligned memory word
- linkAddr  in  data_len  return address for link instructions
- rf_we  out  1  register-file write enable
- rf_waddr  out  addr_len  register-file write address
- rf_wdata  out  data_len  register-file write data
- retired_cnt  out  cnt_len  count of retired instructions

## Operation
- Capture condition: cap = in_valid & !stall & !flush.
- Source mux and load alignment are combinational ahead of the register; all outputs are registered.
- Load alignment (little-endian): byte lane = byte_off; halfword lane = byte_off[1] (byte_off[0] ignored). LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Applies only when wb_sel = MEM.
- On clk edge with cap: rf_we ← reg_write & (dest_reg ≠ 0); rf_waddr ← dest_reg; rf_wdata ← selected data; retired_cnt ← retired_cnt + 1 (wraps to 0 at all-ones).
- On clk edge without cap: rf_we ← 0 (bubble); rf_waddr, rf_wdata hold; counter holds.
- Flush and stall together: flush wins; bubble inserted, in_ready still low.
- Writes to register 0 are suppressed but the instruction still counts as retired.
- Instructions with reg_write = 0 (stores, branches) count as retired.

## Timing
- Latency: one cycle from capture edge to rf_we/rf_waddr/rf_wdata valid; register file writes on the following edge.
- rf_we is high for exactly one cycle per captured writing instruction; never high on consecutive cycles for one instruction.
- in_ready is combinational from stall only.
- Reset (asynchronous, any time, including mid-stall): rf_we = 0, rf_waddr = 0, rf_wdata = 0, retired_cnt = 0, effective immediately; first capture possible on the first edge after rst deasserts.

## Configuration
- WB_LOAD_EXT_EN defined: sub-word alignment/extension as above.
- Not defined: load_type and byte_off ignored; MEM source passes dataFromMemory unchanged (word-only loads); ports remain present.

## Structure
- Shared package wb_pkg: wb_sel encodings (WB_ALU, WB_MEM, WB_LINK), load_type encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU).
- Sub-module load_align: combinational word + byte_off + load_type → extended data; instantiated only under WB_LOAD_EXT_EN.

## Test plan
- ALU path: cap, wb_sel=00, dest=5, dataFromAlu=0x1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678, retired_cnt=1.
- Load extension: dataFromMemory=0x80FF_7F81; LB off=0 → 0xFFFF_FF81; LBU off=0 → 0x0000_0081; LH off=2 → 0xFFFF_80FF; LHU off=3 → 0x0000_80FF.
- Link and $0: wb_sel=10, linkAddr=0x0040_0008, dest=31 → rf_wdata=0x0040_0008, rf_we=1; same with dest=0 → rf_we=0, retired_cnt still increments.
- Stall/flush: stall=1 two cycles → in_ready=0, rf_we=0, counter frozen; flush=1 with stall=1 → bubble, counter frozen.
- Counter wrap: cnt_len=4, retire 17 instructions → retired_cnt=1.
- Async reset mid-stream: rst pulse between edges while rf_we=1 → all outputs 0 immediately, capture resumes the edge after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select and load width/sign kind.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wbSelType;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } loadKind;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load extraction: picks the byte/halfword lane from the aligned word
// and sign- or zero-extends it to the datapath width.
module load_align
    import wb_pkg::*;
#(
    parameter int data_len = 32
) (
    input  logic [data_len-1:0] word,
    input  logic [1:0]          byteOff,
    input  logic [2:0]          loadType,
    output logic [data_len-1:0] dataOut
);

    logic [data_len-1:0] byteShift;
    logic [data_len-1:0] halfShift;

    // Halfword lane uses only byteOff[1]; the low offset bit is ignored.
    assign byteShift = word >> {byteOff, 3'b000};
    assign halfShift = word >> {byteOff[1], 4'b0000};

    always_comb begin
        dataOut = word;
        case (loadType)
            LD_B:    dataOut = {{(data_len-8){byteShift[7]}}, byteShift[7:0]};
            LD_BU:   dataOut = {{(data_len-8){1'b0}}, byteShift[7:0]};
            LD_H:    dataOut = {{(data_len-16){halfShift[15]}}, halfShift[15:0]};
            LD_HU:   dataOut = {{(data_len-16){1'b0}}, halfShift[15:0]};
            default: dataOut = word;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Registered MEM/WB write-back stage: source mux, optional sub-word load extension
// (WB_LOAD_EXT_EN), register-file write port and retired-instruction counter.
module write_back_stage
    import wb_pkg::*;
#(
    parameter int data_len = 32,
    parameter int addr_len = 5,
    parameter int cnt_len  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                stall,
    input  logic                flush,
    input  logic                reg_write,
    input  logic [1:0]          wb_sel,
    input  logic [2:0]          load_type,
    input  logic [1:0]          byte_off,
    input  logic [addr_len-1:0] dest_reg,
    input  logic [data_len-1:0] dataFromAlu,
    input  logic [data_len-1:0] dataFromMemory,
    input  logic [data_len-1:0] linkAddr,
    output logic                rf_we,
    output logic [addr_len-1:0] rf_waddr,
    output logic [data_len-1:0] rf_wdata,
    output logic [cnt_len-1:0]  retired_cnt
);

    logic                cap;
    logic [data_len-1:0] memData;
    logic [data_len-1:0] selData;

    assign in_ready = !stall;
    assign cap      = in_valid & !stall & !flush;

`ifdef WB_LOAD_EXT_EN
    load_align #(.data_len(data_len)) uLoadAlign (
        .word     (dataFromMemory),
        .byteOff  (byte_off),
        .loadType (load_type),
        .dataOut  (memData)
    );
`else
    logic unusedLoadBits;
    assign unusedLoadBits = ^{load_type, byte_off};
    assign memData        = dataFromMemory;
`endif

    // Reserved select code falls back to the ALU result.
    always_comb begin
        selData = dataFromAlu;
        case (wb_sel)
            WB_MEM:  selData = memData;
            WB_LINK: selData = linkAddr;
            default: selData = dataFromAlu;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            retired_cnt <= '0;
        end else if (cap) begin
            rf_we       <= reg_write & (dest_reg != '0);
            rf_waddr    <= dest_reg;
            rf_wdata    <= selData;
            retired_cnt <= retired_cnt + cnt_len'(1);
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule
